// File: rtl/autosa_rubik_wcmd_dispatch.sv
// Rubik write-command dispatcher: pops wcmds and expands them into per-line DMA write requests.
// Optional stall counter on perf_stall_cnt is built only when AUTOSA_RUBIK_WCMD_PERF_EN is defined.
module autosa_rubik_wcmd_dispatch #(
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 13
) (
  input  logic                     autosa_core_clk,
  input  logic                     autosa_core_rstn,
  input  logic                     op_en,
  input  logic [ADDR_W-1:0]        reg2dp_dst_base_addr,
  input  logic [ADDR_W-1:0]        reg2dp_dst_line_stride,
  input  logic [ADDR_W-1:0]        reg2dp_dst_surf_stride,
  input  logic [SIZE_W-1:0]        reg2dp_line_size_m1,
  input  logic                     wcmd_pvld,
  output logic                     wcmd_prdy,
  input  logic [10:0]              wcmd_pd,
  output logic                     dma_wr_req_pvld,
  input  logic                     dma_wr_req_prdy,
  output logic [ADDR_W+SIZE_W-1:0] dma_wr_req_pd,
  output logic                     layer_done,
  output logic                     busy,
  output logic [31:0]              perf_stall_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CMD = 3'd1,
    ISSUE    = 3'd2,
    ADV      = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic       skip;
    logic       layer_end;
    logic       surf_end;
    logic [7:0] lines_m1;
  } wcmd_t;

  state_t              state, state_nx;
  wcmd_t               cmd_in;
  logic                cmd_surf_end, cmd_layer_end;
  logic [7:0]          line_cnt;
  logic [ADDR_W-1:0]   line_stride_q, surf_stride_q;
  logic [ADDR_W-1:0]   surf_ptr, line_ptr;
  logic [SIZE_W-1:0]   line_size_q;
  logic                req_acc;

  assign cmd_in  = wcmd_t'(wcmd_pd);
  assign req_acc = (state == ISSUE) && dma_wr_req_prdy;

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) state <= IDLE;
    else                   state <= state_nx;
  end

  // Outputs are pure state decodes, so wcmd_prdy never looks at wcmd_pvld.
  always_comb begin
    state_nx        = state;
    wcmd_prdy       = 1'b0;
    dma_wr_req_pvld = 1'b0;
    layer_done      = 1'b0;
    busy            = 1'b0;
    case (state)
      IDLE: begin
        if (op_en) state_nx = WAIT_CMD;
      end
      WAIT_CMD: begin
        wcmd_prdy = 1'b1;
        busy      = 1'b1;
        if (wcmd_pvld) state_nx = cmd_in.skip ? ADV : ISSUE;
      end
      ISSUE: begin
        dma_wr_req_pvld = 1'b1;
        busy            = 1'b1;
        if (dma_wr_req_prdy && (line_cnt == 8'd0)) state_nx = ADV;
      end
      ADV: begin
        busy     = 1'b1;
        state_nx = cmd_layer_end ? DONE : WAIT_CMD;
      end
      DONE: begin
        layer_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dma_wr_req_pd = dma_wr_req_pvld ? {line_size_q, line_ptr} : '0;

  // Layer configuration snapshot; later register writes do not disturb a running layer.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      line_stride_q <= '0;
      surf_stride_q <= '0;
      line_size_q   <= '0;
    end else if ((state == IDLE) && op_en) begin
      line_stride_q <= reg2dp_dst_line_stride;
      surf_stride_q <= reg2dp_dst_surf_stride;
      line_size_q   <= reg2dp_line_size_m1;
    end
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      cmd_surf_end  <= 1'b0;
      cmd_layer_end <= 1'b0;
      line_cnt      <= '0;
    end else if ((state == WAIT_CMD) && wcmd_pvld) begin
      cmd_surf_end  <= cmd_in.surf_end;
      cmd_layer_end <= cmd_in.layer_end;
      line_cnt      <= cmd_in.lines_m1;
    end else if (req_acc && (line_cnt != 8'd0)) begin
      line_cnt <= line_cnt - 8'd1;
    end
  end

  // Pointer sums wrap naturally at ADDR_W bits.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      surf_ptr <= '0;
      line_ptr <= '0;
    end else begin
      case (state)
        IDLE: if (op_en) begin
          surf_ptr <= reg2dp_dst_base_addr;
          line_ptr <= reg2dp_dst_base_addr;
        end
        ISSUE: if (dma_wr_req_prdy) line_ptr <= line_ptr + line_stride_q;
        ADV: if (cmd_surf_end) begin
          surf_ptr <= surf_ptr + surf_stride_q;
          line_ptr <= surf_ptr + surf_stride_q;
        end
        default: ;
      endcase
    end
  end

`ifdef AUTOSA_RUBIK_WCMD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn)
      stall_cnt_q <= '0;
    else if ((state == IDLE) && op_en)
      stall_cnt_q <= '0;
    else if (dma_wr_req_pvld && !dma_wr_req_prdy && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_autosa_rubik_wcmd_dispatch.sv
// Bench for autosa_rubik_wcmd_dispatch: directed and random layers against an address-list model.
module tb_autosa_rubik_wcmd_dispatch;
  localparam int AW = 32;
  localparam int SW = 13;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          op_en = 1'b0;
  logic [AW-1:0] base = '0, ls = '0, ss = '0;
  logic [SW-1:0] lsz = '0;
  logic          wcmd_pvld = 1'b0;
  logic          wcmd_prdy;
  logic [10:0]   wcmd_pd = '0;
  logic          dma_pvld;
  logic          dma_prdy = 1'b1;
  logic [AW+SW-1:0] dma_pd;
  logic          layer_done, busy;
  logic [31:0]   perf;

  autosa_rubik_wcmd_dispatch #(.ADDR_W(AW), .SIZE_W(SW)) dut (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn), .op_en(op_en),
    .reg2dp_dst_base_addr(base), .reg2dp_dst_line_stride(ls),
    .reg2dp_dst_surf_stride(ss), .reg2dp_line_size_m1(lsz),
    .wcmd_pvld(wcmd_pvld), .wcmd_prdy(wcmd_prdy), .wcmd_pd(wcmd_pd),
    .dma_wr_req_pvld(dma_pvld), .dma_wr_req_prdy(dma_prdy), .dma_wr_req_pd(dma_pd),
    .layer_done(layer_done), .busy(busy), .perf_stall_cnt(perf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: expected request addresses for the running layer.
  logic [AW-1:0] exp_q[$];
  logic [10:0]   cmd_list[$];
  logic [SW-1:0] exp_lsz;
  int  exp_n, acc_cnt, stall_cnt, done_cnt, done_cyc, last_evt;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  bit  prdy_rnd = 1'b0;

  function automatic logic [10:0] mk(input bit skip, input bit le, input bit se, input int lines_m1);
    logic [7:0] l;
    l = lines_m1[7:0];
    return {skip, le, se, l};
  endfunction

  // Address list derived straight from the layer rules: lines step by line stride,
  // a surface end moves to the next surface origin, skips emit nothing.
  function automatic void build_exp(input logic [AW-1:0] b, input logic [AW-1:0] lstr,
                                    input logic [AW-1:0] sstr);
    logic [AW-1:0] surf, line;
    surf = b;
    line = b;
    exp_q.delete();
    foreach (cmd_list[i]) begin
      if (!cmd_list[i][10])
        for (int k = 0; k <= int'(cmd_list[i][7:0]); k++) begin
          exp_q.push_back(line);
          line = line + lstr;
        end
      if (cmd_list[i][8]) begin
        surf = surf + sstr;
        line = surf;
      end
    end
    exp_n = exp_q.size();
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    dma_prdy = prdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor samples on the falling edge, between DUT updates.
  initial begin
    bit exp_issue;
    bit prev_stall;
    logic [AW+SW-1:0] prev_pd;
    exp_issue  = 1'b0;
    prev_stall = 1'b0;
    prev_pd    = '0;
    forever begin
      @(negedge clk);
      if (!(mon_en && rstn)) begin
        exp_issue  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (exp_issue) chk("first_req_latency", dma_pvld, 1);
        exp_issue = 1'b0;
        if (prev_stall) begin
          chk("stall_hold_vld", dma_pvld, 1);
          chk("stall_hold_pd", dma_pd, prev_pd);
        end
        prev_stall = dma_pvld && !dma_prdy;
        prev_pd    = dma_pd;
        if (dma_pvld && !dma_prdy) stall_cnt++;
        if (dma_pvld && dma_prdy) begin
          acc_cnt++;
          last_evt = cyc;
          if (exp_q.size() == 0) chk("req_over", acc_cnt, exp_n);
          else chk("req_pd", dma_pd, {exp_lsz, exp_q.pop_front()});
        end
        if (wcmd_pvld && wcmd_prdy) begin
          if (wcmd_pd[10]) last_evt = cyc;
          else exp_issue = 1'b1;
        end
        if (layer_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic start_layer(input logic [AW-1:0] b, input logic [AW-1:0] lstr,
                             input logic [AW-1:0] sstr, input logic [SW-1:0] size_m1);
    build_exp(b, lstr, sstr);
    exp_lsz = size_m1;
    acc_cnt = 0; stall_cnt = 0; done_cnt = 0; last_evt = 0; done_cyc = 0;
    base = b; ls = lstr; ss = sstr; lsz = size_m1;
    op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    base = $urandom; ls = $urandom; ss = $urandom; lsz = SW'($urandom);
    chk("busy_after_op_en", busy, 1);
  endtask

  task automatic send_cmd(input logic [10:0] c);
    bit ok;
    int n;
    wcmd_pvld = 1'b1;
    wcmd_pd   = c;
    n = 0;
    do begin
      @(negedge clk);
      ok = wcmd_prdy;
      n++;
      @(posedge clk); #1;
    end while (!ok && n < 5000);
    wcmd_pvld = 1'b0;
    if (!ok) chk("wcmd_accept_timeout", n, 0);
  endtask

  task automatic run_layer(input logic [AW-1:0] b, input logic [AW-1:0] lstr,
                           input logic [AW-1:0] sstr, input logic [SW-1:0] size_m1,
                           input bit rnd);
    int n;
    prdy_rnd = rnd;
    start_layer(b, lstr, sstr, size_m1);
    foreach (cmd_list[i]) send_cmd(cmd_list[i]);
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("layer_done_seen", done_cnt, 1);
    chk("done_latency", done_cyc - last_evt, 2);
    chk("req_count", acc_cnt, exp_n);
    chk("missing_reqs", exp_q.size(), 0);
    chk("busy_after_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done_cnt, 1);
`ifdef AUTOSA_RUBIK_WCMD_PERF_EN
    chk("perf_stalls", perf, stall_cnt);
`else
    chk("perf_tied_zero", perf, 0);
`endif
    prdy_rnd = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wcmd_prdy"}, wcmd_prdy, 0);
    chk({tag, "_pvld"}, dma_pvld, 0);
    chk({tag, "_pd"}, dma_pd, 0);
    chk({tag, "_layer_done"}, layer_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_perf"}, perf, 0);
  endtask

  initial begin
    int n;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic four-line layer.
    cmd_list = '{mk(0, 1, 0, 3)};
    run_layer(32'h1000, 32'h40, 32'h0, 13'h3F, 1'b0);

    // Surface advance.
    cmd_list = '{mk(0, 0, 1, 1), mk(0, 1, 0, 0)};
    run_layer(32'h0, 32'h10, 32'h1000, 13'h7, 1'b0);

    // 256-line command under random backpressure.
    cmd_list = '{mk(0, 1, 0, 255)};
    run_layer(32'h2000_0000, 32'h80, 32'h0, 13'h1FFF, 1'b1);

    // Skip with surface end, then one line.
    cmd_list = '{mk(1, 0, 1, 5), mk(0, 1, 0, 0)};
    run_layer(32'h4000, 32'h20, 32'h800, 13'h1, 1'b0);

    // Address wrap.
    cmd_list = '{mk(0, 1, 0, 1)};
    run_layer(32'hFFFF_FFF0, 32'h20, 32'h0, 13'h10, 1'b0);

    // Layer ending on a skip command.
    cmd_list = '{mk(0, 0, 0, 2), mk(1, 1, 1, 0)};
    run_layer(32'h100, 32'h4, 32'h40, 13'h0, 1'b1);

    // Abort mid-ISSUE after two of eight requests.
    cmd_list = '{mk(0, 1, 0, 7)};
    start_layer(32'h8000, 32'h40, 32'h0, 13'h5);
    send_cmd(cmd_list[0]);
    n = 0;
    while (acc_cnt < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached_two", acc_cnt, 2);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
    done_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_pvld", dma_pvld, 0);
    cmd_list = '{mk(0, 1, 0, 2)};
    run_layer(32'hA000, 32'h100, 32'h0, 13'h2, 1'b0);

    // Random layers.
    for (int t = 0; t < 10; t++) begin
      int nc;
      nc = $urandom_range(1, 5);
      cmd_list.delete();
      for (int i = 0; i < nc; i++)
        cmd_list.push_back(mk($urandom_range(0, 3) == 0, i == nc - 1,
                              1'($urandom_range(0, 1)), $urandom_range(0, 20)));
      run_layer($urandom, $urandom, $urandom, SW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
